dr_req_tracker: RTL and testbench
=================================

# dr_req_tracker

Request-tracking controller for the directory bank's memory path. It hands out a unique DR ID (`drid`) to each L2 request forwarded to memory and records that request's `nid` and `l2id` against it. When memory returns an ack carrying the `drid`, the tracker looks up and releases the entry, then presents the original `nid`/`l2id` so the ack can be routed back to the correct L2. It sits between the `l2todr_req` input flop and `drtomem_req` on the request side, and between `memtodr_ack` and `drtol2_snack` on the return side.

## Interface
Parameters:
- `Entries`, 16, number of outstanding requests tracked; legal range 1..63.
- `NidBits`, 5, width of node ID.
- `L2idBits`, 6, width of L2 request ID.
- `DridBits`, 6, width of DR ID; must satisfy `Entries` < 2^`DridBits`.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `alloc_valid`  in  1  request wants a `drid`.
- `alloc_retry`  out  1  tracker cannot allocate this cycle.
- `alloc_nid`  in  `NidBits`  requester node ID.
- `alloc_l2id`  in  `L2idBits`  requester L2 ID.
- `alloc_drid`  out  `DridBits`  ID that will be assigned if the transfer completes.
- `ack_valid`  in  1  memory ack present.
- `ack_retry`  out  1  tracker cannot take the ack.
- `ack_drid`  in  `DridBits`  ID carried by the memory ack.
- `rsp_valid`  out  1  lookup result valid.
- `rsp_retry`  in  1  downstream stall.
- `rsp_nid`  out  `NidBits`  recovered node ID.
- `rsp_l2id`  out  `L2idBits`  recovered L2 ID.
- `rsp_drid`  out  `DridBits`  echo of the released `drid`.
- `occupancy`  out  `$clog2(Entries+1)`  number of live entries.
- `err_bad_drid`  out  1  sticky flag: an ack arrived for a `drid` that is not live.

## Operation
- Handshake on every channel: a transfer occurs when valid=1 and retry=0 in the same cycle. Valid must not depend on retry.
- State consists of a per-entry live bitmap `vld[Entries-1:0]`, plus per-entry `nid` and `l2id`.
- `drid` encoding is index+1. `drid` 0 is reserved: the L2 interface uses `drid` 0 to mean "not a snoop", so the tracker never issues it.
- Allocation:
  - `alloc_drid` = 1 + lowest index with `vld`=0. It is combinational from registered state and must be stable while `alloc_valid` is held.
  - `alloc_retry` = all entries live, computed from the registered bitmap only.
  - On transfer, the entry's `vld` is set and `nid`/`l2id` are written.
- Ack and lookup:
  - `ack_retry` = `rsp_valid` & `rsp_retry` (single output stage; it accepts while empty or while draining).
  - On an ack transfer with a live `drid`:
    - load `rsp_*` from the entry;
    - set `rsp_valid`=1;
    - clear `vld` for that entry.
  - On an ack transfer with `drid`=0, `drid`>`Entries`, or a non-live entry:
    - the ack is consumed;
    - no response is produced;
    - no state changes;
    - `err_bad_drid` is set to 1.
- `rsp_valid` clears when the response transfers and no new ack is loaded that cycle.
- Simultaneous alloc and ack:
  - Both complete.
  - The entry freed this cycle is not eligible for allocation until the next cycle, because allocation sees registered `vld`.
  - When full, a same-cycle free does not drop `alloc_retry`.
- An ack for a `drid` allocated in the same cycle sees the entry as non-live, so the error path applies.
- `occupancy` = popcount of `vld`, updated as +1, −1 or 0 per cycle.
- Reset outputs:
  - `alloc_retry`=0, `alloc_drid`=1, `ack_retry`=0;
  - `rsp_valid`=0, `rsp_nid`=0, `rsp_l2id`=0, `rsp_drid`=0;
  - `occupancy`=0, `err_bad_drid`=0.
- Reset mid-operation drops all outstanding entries and any pending response; later acks for old `drid`s flag an error.

## Timing
- Alloc has zero-cycle latency: the `drid` is known in the transfer cycle, and the entry is live from the next edge.
- Ack-to-response latency is 1 cycle (registered `rsp_*`).
- With `rsp_retry`=0, throughput is 1 alloc plus 1 ack per cycle.
- The lowest-free search is a combinational chain of depth `Entries`. No pipelining is required at `Entries` ≤ 63.

## Structure
- Add to `scmem.vh`:
  - `I_drtr_entry_type` (`nid`, `l2id`);
  - the `DR_DRID_NONE`=0 constant;
  - the width constants shared with the `drtomem_req`/`drtol2_snack` types.
- One sub-module, `dr_free_enc`: find the lowest zero bit in the bitmap, outputting index and full flag. It is reusable for the displacement-ack tracker.
- `rsp_*` is a plain registered stage. It must not be wrapped in `fflop`, since occupancy and error depend on same-cycle consumption.

## Test plan
- Reset, then alloc `nid`=3 and `l2id`=7 → `alloc_drid`=1 and `occupancy`=1. Ack `drid`=1 → the next cycle shows `rsp_valid`=1, `nid`=3, `l2id`=7, `drid`=1, and `occupancy`=0.
- Allocate 16 times back-to-back → `drid` 1..16 are issued and `alloc_retry`=1. Ack `drid`=5 in the same cycle as a held alloc → retry stays high that cycle. The next cycle, `alloc_drid`=5.
- Out-of-order acks: with `drid` 1,2,3 live, ack 3, then 1, then 2 → responses carry the matching `nid`/`l2id` in order 3,1,2.
- Ack `drid`=0, then `drid`=9 while entry 9 is free → no `rsp_valid`, `err_bad_drid`=1 (sticky), and `occupancy` unchanged.
- Hold `rsp_retry`=1 with one response pending, then present an ack → `ack_retry`=1 and the response is stable. Release → the first response transfers and the second ack is accepted in the same cycle, appearing the cycle after.
- Assert `reset` with 4 entries live and `rsp_valid`=1 → the next cycle shows `occupancy`=0, `rsp_valid`=0, and `alloc_drid`=1.

Source files
------------

// File: rtl/dr_req_tracker_pkg.sv
// Shared types and constants for the directory-bank request tracker.
// DR ID 0 is reserved on the L2 interface to mean "not a snoop".
package dr_req_tracker_pkg;

    localparam int DR_ENTRIES   = 16;
    localparam int DR_NID_BITS  = 5;
    localparam int DR_L2ID_BITS = 6;
    localparam int DR_DRID_BITS = 6;

    localparam logic [DR_DRID_BITS-1:0] DR_DRID_NONE = '0;

    typedef struct packed {
        logic [DR_NID_BITS-1:0]  nid;
        logic [DR_L2ID_BITS-1:0] l2id;
    } I_drtr_entry_type;

    // Index width for an N-entry table; never zero so single-entry builds still elaborate.
    function automatic int enc_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dr_req_tracker_if.sv
// Alloc / ack / response channels of the request tracker.
// Every channel: a transfer happens in a cycle where valid=1 and retry=0; valid never depends on retry.
interface dr_req_tracker_if
    import dr_req_tracker_pkg::*;
#(
    parameter int NidBits  = DR_NID_BITS,
    parameter int L2idBits = DR_L2ID_BITS,
    parameter int DridBits = DR_DRID_BITS
);
    logic                alloc_valid;
    logic                alloc_retry;
    logic [NidBits-1:0]  alloc_nid;
    logic [L2idBits-1:0] alloc_l2id;
    logic [DridBits-1:0] alloc_drid;

    logic                ack_valid;
    logic                ack_retry;
    logic [DridBits-1:0] ack_drid;

    logic                rsp_valid;
    logic                rsp_retry;
    logic [NidBits-1:0]  rsp_nid;
    logic [L2idBits-1:0] rsp_l2id;
    logic [DridBits-1:0] rsp_drid;

    modport slave (
        input  alloc_valid, alloc_nid, alloc_l2id, ack_valid, ack_drid, rsp_retry,
        output alloc_retry, alloc_drid, ack_retry, rsp_valid, rsp_nid, rsp_l2id, rsp_drid
    );

    modport master (
        output alloc_valid, alloc_nid, alloc_l2id, ack_valid, ack_drid, rsp_retry,
        input  alloc_retry, alloc_drid, ack_retry, rsp_valid, rsp_nid, rsp_l2id, rsp_drid
    );
endinterface

// File: rtl/dr_req_tracker_free_enc.sv
// Lowest-zero finder over a live bitmap: index of the first free slot plus an all-full flag.
// Kept generic so other trackers (e.g. displacement acks) can share it.
module dr_free_enc #(
    parameter int Entries = 16,
    parameter int IdxBits = 4
) (
    input  logic [Entries-1:0] vld_i,
    output logic [IdxBits-1:0] idx_o,
    output logic               full_o
);

    always_comb begin
        idx_o  = '0;
        full_o = &vld_i;
        // Scan from the top so the lowest free index is the last one written.
        for (int i = Entries - 1; i >= 0; i--) begin
            if (!vld_i[i]) begin
                idx_o = IdxBits'(i);
            end
        end
    end

endmodule

// File: rtl/dr_req_tracker.sv
// Hands out DR IDs (index+1) to requests headed to memory and recovers nid/l2id
// when memory acks that ID, presenting them through a single registered response stage.
module dr_req_tracker
    import dr_req_tracker_pkg::*;
#(
    parameter int Entries  = DR_ENTRIES,
    parameter int NidBits  = DR_NID_BITS,
    parameter int L2idBits = DR_L2ID_BITS,
    parameter int DridBits = DR_DRID_BITS,
    localparam int OccBits = $clog2(Entries + 1)
) (
    input  logic               clk,
    input  logic               reset,
    dr_req_tracker_if.slave    bus,
    output logic [OccBits-1:0] occupancy,
    output logic               err_bad_drid
);

    localparam int IdxBits = enc_bits(Entries);

    logic [Entries-1:0]  vld_q, vld_d;
    logic [NidBits-1:0]  nid_q  [Entries];
    logic [L2idBits-1:0] l2id_q [Entries];
    logic [OccBits-1:0]  occ_q, occ_d;
    logic                err_q, err_d;

    logic                rsp_valid_q, rsp_valid_d;
    logic [NidBits-1:0]  rsp_nid_q, rsp_nid_d;
    logic [L2idBits-1:0] rsp_l2id_q, rsp_l2id_d;
    logic [DridBits-1:0] rsp_drid_q, rsp_drid_d;

    logic [IdxBits-1:0]  free_idx;
    logic                full;
    logic                alloc_fire;
    logic                ack_retry;
    logic                ack_fire;
    logic                ack_in_range;
    logic                ack_good;
    logic [IdxBits-1:0]  ack_idx;

    dr_free_enc #(
        .Entries (Entries),
        .IdxBits (IdxBits)
    ) u_free_enc (
        .vld_i  (vld_q),
        .idx_o  (free_idx),
        .full_o (full)
    );

    // Allocation only looks at registered state, so a same-cycle release never reopens a slot early.
    assign alloc_fire = bus.alloc_valid & ~full;
    assign ack_retry  = rsp_valid_q & bus.rsp_retry;
    assign ack_fire   = bus.ack_valid & ~ack_retry;

    assign ack_in_range = (bus.ack_drid != DridBits'(DR_DRID_NONE)) &&
                          (bus.ack_drid <= DridBits'(Entries));
    assign ack_idx      = IdxBits'(bus.ack_drid - DridBits'(1));
    assign ack_good     = ack_fire & ack_in_range & vld_q[ack_idx];

    always_comb begin
        vld_d = vld_q;
        if (alloc_fire) begin
            vld_d[free_idx] = 1'b1;
        end
        if (ack_good) begin
            vld_d[ack_idx] = 1'b0;
        end
    end

    assign occ_d = occ_q + OccBits'(alloc_fire) - OccBits'(ack_good);
    assign err_d = err_q | (ack_fire & ~ack_good);

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_nid_d   = rsp_nid_q;
        rsp_l2id_d  = rsp_l2id_q;
        rsp_drid_d  = rsp_drid_q;
        if (ack_good) begin
            rsp_valid_d = 1'b1;
            rsp_nid_d   = nid_q[ack_idx];
            rsp_l2id_d  = l2id_q[ack_idx];
            rsp_drid_d  = bus.ack_drid;
        end else if (rsp_valid_q && !bus.rsp_retry) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q       <= '0;
            occ_q       <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_nid_q   <= '0;
            rsp_l2id_q  <= '0;
            rsp_drid_q  <= '0;
        end else begin
            vld_q       <= vld_d;
            occ_q       <= occ_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_nid_q   <= rsp_nid_d;
            rsp_l2id_q  <= rsp_l2id_d;
            rsp_drid_q  <= rsp_drid_d;
        end
    end

    // Payload storage is only read for live entries, so it needs no reset.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            nid_q[free_idx]  <= bus.alloc_nid;
            l2id_q[free_idx] <= bus.alloc_l2id;
        end
    end

    assign bus.alloc_retry = full;
    assign bus.alloc_drid  = DridBits'(free_idx) + DridBits'(1);
    assign bus.ack_retry   = ack_retry;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_nid     = rsp_nid_q;
    assign bus.rsp_l2id    = rsp_l2id_q;
    assign bus.rsp_drid    = rsp_drid_q;
    assign occupancy       = occ_q;
    assign err_bad_drid    = err_q;

endmodule

// File: tb/tb_dr_req_tracker.sv
// Bench for dr_req_tracker: vector table for single-cycle behaviour, hand sequences for
// fill/backpressure/reset, and a response scoreboard fed when acks are driven.
module tb_dr_req_tracker;

    localparam int NB = 5;
    localparam int LB = 6;
    localparam int DB = 6;
    localparam int EW = NB + LB + DB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] occupancy;
    logic       err_bad_drid;

    dr_req_tracker_if #(.NidBits(NB), .L2idBits(LB), .DridBits(DB)) bus ();

    dr_req_tracker #(
        .Entries  (16),
        .NidBits  (NB),
        .L2idBits (LB),
        .DridBits (DB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .occupancy    (occupancy),
        .err_bad_drid (err_bad_drid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [EW-1:0] exp_q[$];

    typedef struct {
        bit av; int an; int al; bit kv; int kd; bit rr;
        int e_aretry; int e_adrid; int e_kretry; int e_occ; int e_err; int e_rvalid;
        bit push; int p_nid; int p_l2id;
    } vec_t;
    vec_t vecs[$];

    int fill_nid[16];
    int fill_l2[16];

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    function automatic void sb_push(input int n, input int l, input int d);
        exp_q.push_back({NB'(n), LB'(l), DB'(d)});
    endfunction

    task automatic drive(input bit av, input int an, input int al,
                         input bit kv, input int kd, input bit rr);
        bus.alloc_valid = av;
        bus.alloc_nid   = NB'(an);
        bus.alloc_l2id  = LB'(al);
        bus.ack_valid   = kv;
        bus.ack_drid    = DB'(kd);
        bus.rsp_retry   = rr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        repeat (2) next_cycle();
        reset = 1'b0;
    endtask

    task automatic add_vec(input bit av, input int an, input int al, input bit kv, input int kd,
                           input bit rr, input int ea, input int ed, input int ek, input int eo,
                           input int ee, input int ev, input bit pu, input int pn, input int pl);
        vec_t v;
        v.av = av; v.an = an; v.al = al; v.kv = kv; v.kd = kd; v.rr = rr;
        v.e_aretry = ea; v.e_adrid = ed; v.e_kretry = ek; v.e_occ = eo; v.e_err = ee; v.e_rvalid = ev;
        v.push = pu; v.p_nid = pn; v.p_l2id = pl;
        vecs.push_back(v);
    endtask

    // Scoreboard: a response transfers at the next edge whenever valid is up and retry is low.
    always @(negedge clk) begin
        if (!reset && bus.rsp_valid && !bus.rsp_retry) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rsp_unexpected: got drid %0d, required no response", bus.rsp_drid);
            end else begin
                check("rsp_payload", int'({bus.rsp_nid, bus.rsp_l2id, bus.rsp_drid}),
                      int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // av an al kv kd rr | aretry adrid kretry occ err rvalid | push nid l2id
        add_vec(1, 3, 7,  0, 0,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, 0, 0,  1, 1,  0, 0, 2, 0, 1, 0, 0, 1, 3, 7);
        add_vec(0, 0, 0,  0, 0,  0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        add_vec(1, 1, 11, 0, 0,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add_vec(1, 2, 22, 0, 0,  0, 0, 2, 0, 1, 0, 0, 0, 0, 0);
        add_vec(1, 4, 33, 0, 0,  0, 0, 3, 0, 2, 0, 0, 0, 0, 0);
        add_vec(0, 0, 0,  1, 3,  0, 0, 4, 0, 3, 0, 0, 1, 4, 33);
        add_vec(0, 0, 0,  1, 1,  0, 0, 3, 0, 2, 0, 1, 1, 1, 11);
        add_vec(0, 0, 0,  1, 2,  0, 0, 1, 0, 1, 0, 1, 1, 2, 22);
        add_vec(0, 0, 0,  0, 0,  0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        add_vec(0, 0, 0,  1, 0,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, 0, 0,  1, 9,  0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        add_vec(1, 5, 44, 0, 0,  0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        add_vec(0, 0, 0,  1, 9,  0, 0, 2, 0, 1, 1, 0, 0, 0, 0);
        add_vec(0, 0, 0,  1, 17, 0, 0, 2, 0, 1, 1, 0, 0, 0, 0);
        add_vec(0, 0, 0,  1, 1,  0, 0, 2, 0, 1, 1, 0, 1, 5, 44);
        add_vec(0, 0, 0,  0, 0,  0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
        add_vec(1, 6, 50, 1, 1,  0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        add_vec(0, 0, 0,  0, 0,  0, 0, 2, 0, 1, 1, 0, 0, 0, 0);
        add_vec(0, 0, 0,  1, 1,  0, 0, 2, 0, 1, 1, 0, 1, 6, 50);
        add_vec(0, 0, 0,  0, 0,  0, 0, 1, 0, 0, 1, 1, 0, 0, 0);

        do_reset();
        @(negedge clk);
        check("reset_alloc_retry", int'(bus.alloc_retry), 0);
        check("reset_alloc_drid", int'(bus.alloc_drid), 1);
        check("reset_ack_retry", int'(bus.ack_retry), 0);
        check("reset_rsp_valid", int'(bus.rsp_valid), 0);
        check("reset_rsp_fields", int'({bus.rsp_nid, bus.rsp_l2id, bus.rsp_drid}), 0);
        check("reset_occupancy", int'(occupancy), 0);
        check("reset_err", int'(err_bad_drid), 0);
        next_cycle();

        foreach (vecs[i]) begin
            drive(vecs[i].av, vecs[i].an, vecs[i].al, vecs[i].kv, vecs[i].kd, vecs[i].rr);
            if (vecs[i].push) sb_push(vecs[i].p_nid, vecs[i].p_l2id, vecs[i].kd);
            @(negedge clk);
            check($sformatf("vec%0d_alloc_retry", i), int'(bus.alloc_retry), vecs[i].e_aretry);
            check($sformatf("vec%0d_alloc_drid", i), int'(bus.alloc_drid), vecs[i].e_adrid);
            check($sformatf("vec%0d_ack_retry", i), int'(bus.ack_retry), vecs[i].e_kretry);
            check($sformatf("vec%0d_occupancy", i), int'(occupancy), vecs[i].e_occ);
            check($sformatf("vec%0d_err", i), int'(err_bad_drid), vecs[i].e_err);
            check($sformatf("vec%0d_rsp_valid", i), int'(bus.rsp_valid), vecs[i].e_rvalid);
            next_cycle();
        end

        // Fill all 16 entries back to back, then free one while the alloc is held.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            fill_nid[i] = i;
            fill_l2[i]  = $urandom_range(0, 63);
            drive(1, fill_nid[i], fill_l2[i], 0, 0, 0);
            @(negedge clk);
            check($sformatf("fill%0d_drid", i), int'(bus.alloc_drid), i + 1);
            check($sformatf("fill%0d_retry", i), int'(bus.alloc_retry), 0);
            next_cycle();
        end
        drive(1, 20, 40, 1, 5, 0);
        sb_push(fill_nid[4], fill_l2[4], 5);
        @(negedge clk);
        check("full_alloc_retry", int'(bus.alloc_retry), 1);
        check("full_occupancy", int'(occupancy), 16);
        check("full_ack_retry", int'(bus.ack_retry), 0);
        next_cycle();
        drive(1, 21, 41, 0, 0, 0);
        fill_nid[4] = 21;
        fill_l2[4]  = 41;
        @(negedge clk);
        check("freed_alloc_retry", int'(bus.alloc_retry), 0);
        check("freed_alloc_drid", int'(bus.alloc_drid), 5);
        check("freed_occupancy", int'(occupancy), 15);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("refill_alloc_retry", int'(bus.alloc_retry), 1);
        check("refill_occupancy", int'(occupancy), 16);
        next_cycle();

        // Response backpressure: second ack waits until the pending response drains.
        drive(0, 0, 0, 1, 1, 1);
        sb_push(fill_nid[0], fill_l2[0], 1);
        @(negedge clk);
        check("bp_first_ack_retry", int'(bus.ack_retry), 0);
        next_cycle();
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, 1, 2, 1);
            @(negedge clk);
            check($sformatf("bp_hold%0d_ack_retry", c), int'(bus.ack_retry), 1);
            check($sformatf("bp_hold%0d_rsp_valid", c), int'(bus.rsp_valid), 1);
            check($sformatf("bp_hold%0d_rsp", c), int'({bus.rsp_nid, bus.rsp_l2id, bus.rsp_drid}),
                  int'({NB'(fill_nid[0]), LB'(fill_l2[0]), DB'(1)}));
            next_cycle();
        end
        drive(0, 0, 0, 1, 2, 0);
        sb_push(fill_nid[1], fill_l2[1], 2);
        @(negedge clk);
        check("bp_release_ack_retry", int'(bus.ack_retry), 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("bp_second_rsp_valid", int'(bus.rsp_valid), 1);
        check("bp_second_rsp_drid", int'(bus.rsp_drid), 2);
        check("bp_occupancy", int'(occupancy), 14);
        next_cycle();
        @(negedge clk);
        check("bp_drained_rsp_valid", int'(bus.rsp_valid), 0);
        next_cycle();

        // Reset with live entries and a stalled response pending.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 10 + i, i, 0, 0, 0);
            next_cycle();
        end
        drive(0, 0, 0, 1, 3, 1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        check("prereset_rsp_valid", int'(bus.rsp_valid), 1);
        check("prereset_rsp_drid", int'(bus.rsp_drid), 3);
        check("prereset_occupancy", int'(occupancy), 3);
        next_cycle();
        drive(1, 0, 0, 0, 0, 1);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("midreset_occupancy", int'(occupancy), 0);
        check("midreset_rsp_valid", int'(bus.rsp_valid), 0);
        check("midreset_alloc_drid", int'(bus.alloc_drid), 1);
        check("midreset_rsp_fields", int'({bus.rsp_nid, bus.rsp_l2id, bus.rsp_drid}), 0);
        check("midreset_err", int'(err_bad_drid), 0);
        next_cycle();
        drive(0, 0, 0, 1, 2, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("stale_ack_err", int'(err_bad_drid), 1);
        check("stale_ack_rsp_valid", int'(bus.rsp_valid), 0);
        check("stale_ack_occupancy", int'(occupancy), 0);
        next_cycle();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
